// File: rtl/aes_pkg.sv
// AES-128 shared definitions: round count, FSM encoding, S-box table and GF(2^8) helpers.
package aes_pkg;

  localparam int NR = 10;
  localparam logic [3:0] NR_LAST = 4'(NR);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Entry 0 sits at the MSB; each 128-bit row covers 16 consecutive entries.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b ends at bit 2047 - 8*b, which is {~b, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round r key is the r-th 128-bit slice counting down from the MSB.
  function automatic logic [127:0] rk(input logic [1407:0] round_key, input logic [3:0] r);
    logic [1407:0] sh;
    sh = round_key << {r, 7'b0};
    return sh[1407 -: 128];
  endfunction

endpackage

// File: rtl/aes_round.sv
// Combinational AES round: SubBytes, ShiftRows, MixColumns (bypassed when last), AddRoundKey.
// With AES_SBOX_REG_EN the SubBytes result leaves on sub and the remaining half consumes sb.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] st,
`ifdef AES_SBOX_REG_EN
  input  logic [127:0] sb,
  output logic [127:0] sub,
`endif
  input  logic [127:0] rkey,
  input  logic         last,
  output logic [127:0] st_next
);

  logic [127:0] sub_w;
  logic [127:0] src;
  logic [127:0] shf;
  logic [127:0] mix;

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  always_comb begin
    sub_w = '0;
    for (int i = 0; i < 16; i++) begin
      sub_w[127-8*i -: 8] = sbox(st[127-8*i -: 8]);
    end
  end

`ifdef AES_SBOX_REG_EN
  assign sub = sub_w;
  assign src = sb;
`else
  assign src = sub_w;
`endif

  // Byte 4*c+r holds row r of column c; row r rotates left by r columns.
  always_comb begin
    shf = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shf[127-8*(4*c+r) -: 8] = src[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  always_comb begin
    mix = '0;
    for (int c = 0; c < 4; c++) begin
      mix[127-32*c -: 32] = mix_col(shf[127-32*c -: 32]);
    end
  end

  assign st_next = (last ? shf : mix) ^ rkey;

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor, one round per clock, valid/ready on both sides.
// Define AES_SBOX_REG_EN to register SubBytes, splitting each round over two clocks.
module aes_encrypt_iter
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  plaintext,
  input  logic [1407:0] round_key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  ciphertext,
  output logic          busy
);

  state_t       state;
  state_t       state_nxt;
  logic [3:0]   rnd;
  logic [127:0] st;
  logic [127:0] st_next;
  logic [127:0] cur_rk;
  logic         rnd_ok;
  logic         accept;
  logic         round_end;
  logic         out_valid_q;
  logic         busy_q;

`ifdef AES_SBOX_REG_EN
  logic         phase;
  logic         sub_load;
  logic [127:0] sb;
  logic [127:0] sub;
`endif

  assign rnd_ok = (rnd >= 4'd1) && (rnd <= NR_LAST);
  assign cur_rk = rk(round_key, rnd);

  aes_round u_round (
    .st      (st),
`ifdef AES_SBOX_REG_EN
    .sb      (sb),
    .sub     (sub),
`endif
    .rkey    (cur_rk),
    .last    (rnd == NR_LAST),
    .st_next (st_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nxt = ST_ROUND;
      ST_ROUND: begin
        if (!rnd_ok) begin
          state_nxt = ST_IDLE;
        end else if (round_end && (rnd == NR_LAST)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    accept    = 1'b0;
    round_end = 1'b0;
`ifdef AES_SBOX_REG_EN
    sub_load  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      ST_ROUND: begin
        if (rnd_ok) begin
`ifdef AES_SBOX_REG_EN
          round_end = phase;
          sub_load  = !phase;
`else
          round_end = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  // rnd holds at NR on the last round so it never leaves 1..NR once loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd         <= 4'd0;
      st          <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef AES_SBOX_REG_EN
      phase       <= 1'b0;
      sb          <= '0;
`endif
    end else begin
      out_valid_q <= (state_nxt == ST_DONE);
      busy_q      <= (state_nxt != ST_IDLE);
      if (accept) begin
        st  <= plaintext ^ rk(round_key, 4'd0);
        rnd <= 4'd1;
`ifdef AES_SBOX_REG_EN
        phase <= 1'b0;
`endif
      end else if (round_end) begin
        st <= st_next;
        if (rnd != NR_LAST) begin
          rnd <= rnd + 4'd1;
        end
`ifdef AES_SBOX_REG_EN
        phase <= 1'b0;
      end else if (sub_load) begin
        sb    <= sub;
        phase <= 1'b1;
`endif
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign ciphertext = st;

endmodule
